// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores into byte lanes/strobes and drains them in order over a req/ack port.
// Optional macro STORE_BUF_FWD_HIT_EN adds ld_addr/ld_hit word-address conflict detection.
module store_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [2:0]       st_func,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ades,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  output logic [PTR_W:0]   buf_count,
  output logic             buf_empty
`ifdef STORE_BUF_FWD_HIT_EN
  ,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit
`endif
);

  typedef enum logic [2:0] {
    FUNC_SB = 3'b000,
    FUNC_SH = 3'b010,
    FUNC_SW = 3'b100
  } st_func_e;

  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  st_func_e    func;
  logic        full;
  logic        fire;
  logic        deq;
  logic        enq;
  logic        func_ok;
  logic        misaligned;
  logic [31:0] lane_data;
  logic [3:0]  lane_strb;

  assign func      = st_func_e'(st_func);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign st_ready  = !full;
  assign buf_empty = (count == '0);
  assign buf_count = count;
  assign mem_req   = !buf_empty;
  assign fire      = st_valid && st_ready;
  assign deq       = mem_ack && mem_req;
  assign enq       = fire && func_ok && !misaligned;

  always_comb begin
    func_ok    = 1'b1;
    misaligned = 1'b0;
    lane_data  = st_data;
    lane_strb  = 4'b1111;
    case (func)
      FUNC_SB: begin
        lane_data = {4{st_data[7:0]}};
        lane_strb = 4'b0001 << st_addr[1:0];
      end
      FUNC_SH: begin
        lane_data  = {2{st_data[15:0]}};
        lane_strb  = st_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = st_addr[0];
      end
      FUNC_SW: misaligned = (st_addr[1:0] != 2'b00);
      default: func_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      st_ades <= 1'b0;
    end else begin
      st_ades <= fire && func_ok && misaligned;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: the head is masked by buf_empty and count gates every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= st_addr[31:2];
      data_q[wr_ptr] <= lane_data;
      strb_q[wr_ptr] <= lane_strb;
    end
  end

  assign mem_addr  = buf_empty ? '0 : {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = buf_empty ? '0 : data_q[rd_ptr];
  assign mem_wstrb = buf_empty ? '0 : strb_q[rd_ptr];

`ifdef STORE_BUF_FWD_HIT_EN
  logic unused_ld_low;
  assign unused_ld_low = ^ld_addr[1:0];

  // The head still counts while it is being acked, so the walk uses the pre-edge count.
  always_comb begin
    ld_hit = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count) && (addr_q[rd_ptr + PTR_W'(k)] == ld_addr[31:2]))
        ld_hit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic             clk;
  logic             rst;
  logic             st_valid;
  logic             st_ready;
  logic [2:0]       st_func;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             st_ades;
  logic             mem_req;
  logic             mem_ack;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wstrb;
  logic [PTR_W:0]   buf_count;
  logic             buf_empty;
`ifdef STORE_BUF_FWD_HIT_EN
  logic [31:0]      ld_addr;
  logic             ld_hit;
`endif

  store_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_func(st_func),
    .st_addr(st_addr), .st_data(st_data), .st_ades(st_ades),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .buf_count(buf_count), .buf_empty(buf_empty)
`ifdef STORE_BUF_FWD_HIT_EN
    , .ld_addr(ld_addr), .ld_hit(ld_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t q[$];
  bit   ades_exp;
  int   vectors;
  int   miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store semantics from access size n: lane b carries data byte (b mod n); strobes cover [off, off+n).
  task automatic build(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       output bit ok, output bit mis, output ent_t e);
    int n;
    int off;
    case (f)
      3'b000:  n = 1;
      3'b010:  n = 2;
      3'b100:  n = 4;
      default: n = 0;
    endcase
    off = int'(a[1:0]);
    ok  = (n != 0);
    mis = ok && ((off % n) != 0);
    e.waddr = a[31:2];
    e.data  = '0;
    e.strb  = '0;
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        e.data[8*b +: 8] = d[8*(b % n) +: 8];
        e.strb[b]        = (b >= off) && (b < off + n);
      end
    end
  endtask

  task automatic model_edge();
    bit   ok, mis, fire, pop;
    ent_t e;
    if (rst) begin
      q.delete();
      ades_exp = 1'b0;
    end else begin
      build(st_func, st_addr, st_data, ok, mis, e);
      fire = st_valid && (q.size() < DEPTH);
      pop  = mem_ack && (q.size() > 0);
      ades_exp = fire && ok && mis;
      if (pop) void'(q.pop_front());
      if (fire && ok && !mis) q.push_back(e);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea, ed;
    logic [3:0]  es;
    ea = '0; ed = '0; es = '0;
    if (q.size() > 0) begin
      ea = {q[0].waddr, 2'b00};
      ed = q[0].data;
      es = q[0].strb;
    end
    chk("buf_count", 32'(buf_count), 32'(q.size()));
    chk("buf_empty", 32'(buf_empty), 32'(q.size() == 0));
    chk("st_ready",  32'(st_ready),  32'(q.size() < DEPTH));
    chk("mem_req",   32'(mem_req),   32'(q.size() != 0));
    chk("st_ades",   32'(st_ades),   32'(ades_exp));
    chk("mem_addr",  mem_addr,  ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(es));
`ifdef STORE_BUF_FWD_HIT_EN
    begin
      bit hit;
      hit = 1'b0;
      foreach (q[i]) if (q[i].waddr == ld_addr[31:2]) hit = 1'b1;
      chk("ld_hit", 32'(ld_hit), 32'(hit));
    end
`endif
  endtask

  task automatic step(input logic v, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic ack, input logic r);
    st_valid = v; st_func = f; st_addr = a; st_data = d; mem_ack = ack; rst = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b100;

  initial begin
    vectors = 0; miscompares = 0; ades_exp = 1'b0;
    st_valid = 0; st_func = SW; st_addr = '0; st_data = '0; mem_ack = 0; rst = 1;
`ifdef STORE_BUF_FWD_HIT_EN
    ld_addr = '0;
`endif
    step(0, SW, 0, 0, 0, 1);
    step(0, SW, 0, 0, 1, 1);
    chk("reset_req", 32'(mem_req), 32'd0);
    chk("reset_ready", 32'(st_ready), 32'd1);

    // SB at byte 3 with ack held high
    step(1, SB, 32'h1000_0003, 32'h0000_00A5, 1, 0);
    chk("sb_addr", mem_addr, 32'h1000_0000);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    step(0, SB, 0, 0, 1, 0);
    chk("sb_drained", 32'(buf_empty), 32'd1);

    // Misaligned SH then SW
    step(1, SH, 32'h2000_0001, 32'h1234_5678, 0, 0);
    chk("sh_ades", 32'(st_ades), 32'd1);
    chk("sh_count", 32'(buf_count), 32'd0);
    step(1, SW, 32'h2000_0006, 32'h1234_5678, 0, 0);
    chk("sw_ades", 32'(st_ades), 32'd1);
    step(0, SW, 0, 0, 0, 0);
    chk("ades_pulse", 32'(st_ades), 32'd0);

    // Fill with ack low, fifth store must wait
    for (int i = 1; i <= 5; i++) step(1, SW, 32'h4000_0000 + 32'(4*i), 32'(i), 0, 0);
    chk("full_count", 32'(buf_count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    chk("full_head", mem_wdata, 32'd1);
    step(1, SW, 32'h4000_0014, 32'd5, 1, 0);
    chk("drain_head2", mem_wdata, 32'd2);
    step(1, SW, 32'h4000_0014, 32'd5, 1, 0);
    for (int i = 0; i < 5; i++) step(0, SW, 0, 0, 1, 0);
    chk("drain_done", 32'(buf_empty), 32'd1);

    // Simultaneous enqueue and dequeue at count 2
    step(1, SW, 32'h5000_0000, 32'h11, 0, 0);
    step(1, SH, 32'h5000_0002, 32'h22, 0, 0);
    step(1, SB, 32'h5000_0005, 32'h77, 1, 0);
    chk("simul_count", 32'(buf_count), 32'd2);
    for (int i = 0; i < 3; i++) step(0, SW, 0, 0, 1, 0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, SW, 32'h6000_0000 + 32'(4*i), 32'(i), 0, 0);
    step(0, SW, 0, 0, 0, 1);
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    step(0, SW, 0, 0, 1, 0);
    step(0, SW, 0, 0, 1, 0);

`ifdef STORE_BUF_FWD_HIT_EN
    ld_addr = 32'h3000_000A;
    step(1, SW, 32'h3000_0008, 32'hCAFE_F00D, 0, 0);
    chk("hit_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h3000_000C;
    #1;
    chk("hit_next_word", 32'(ld_hit), 32'd0);
    ld_addr = 32'h3000_0008;
    step(0, SW, 0, 0, 1, 0);
    chk("hit_after_ack", 32'(ld_hit), 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  f;
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0, 1, 2: f = SB;
        3, 4, 5: f = SH;
        6, 7, 8: f = SW;
        default: f = 3'($urandom_range(0, 7));
      endcase
      a = {28'h700_0000 | 28'($urandom_range(0, 3)), 4'($urandom)};
`ifdef STORE_BUF_FWD_HIT_EN
      ld_addr = {28'h700_0000 | 28'($urandom_range(0, 3)), 4'($urandom)};
`endif
      step(($urandom_range(0, 3) != 0), f, a, $urandom, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Store-side counterpart of the load extension path.
- Takes a store from the MEM stage: SB/SH/SW opcode, byte address and raw register data.
- Checks alignment, builds byte lanes and byte strobes, and queues the write in a small in-order FIFO.
- Drains the FIFO to the data-memory port with a req/ack handshake, so the pipeline does not stall on single-cycle memory latency.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); must be kept consistent with DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- st_valid  in  1  store request present this cycle.
- st_ready  out  1  buffer can accept a store; equals !full.
- st_func  in  3  000 SB, 010 SH, 100 SW; other codes are invalid.
- st_addr  in  32  byte address of the store.
- st_data  in  32  rt register value; the low byte or half is used for SB/SH.
- st_ades  out  1  store address-error pulse, registered.
- mem_req  out  1  head entry valid; write requested.
- mem_ack  in  1  memory accepted the head write this cycle.
- mem_addr  out  32  word address {st_addr[31:2], 2'b00} of the head entry.
- mem_wdata  out  32  lane-placed write data of the head entry.
- mem_wstrb  out  4  byte strobes of the head entry; bit i enables lane [8i+7:8i].
- buf_count  out  PTR_W+1  number of occupied entries.
- buf_empty  out  1  buf_count == 0.

Behaviour:
- Reset (rst=1 at an edge):
  - Read pointer, write pointer and count clear to 0; st_ades clears to 0.
  - Outputs after reset: mem_req=0, st_ready=1, buf_empty=1.
  - mem_addr, mem_wdata and mem_wstrb read 0 while empty.
  - Reset mid-drain discards every buffered store, including a head with mem_req=1.
- Accept: the handshake fires when st_valid && st_ready.
  - st_ready depends only on count, never on mem_ack. When full, a same-cycle dequeue does not open a slot until the next cycle.
- Lane placement (accepted, aligned):
  - SB: wdata = {4{st_data[7:0]}}, wstrb = 4'b0001 << st_addr[1:0].
  - SH: wdata = {2{st_data[15:0]}}, wstrb = st_addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = st_data, wstrb = 4'b1111.
- Alignment error:
  - Applies to SH with st_addr[0]=1, and to SW with st_addr[1:0]!=0.
  - The store is accepted but not enqueued.
  - st_ades=1 for exactly the cycle after the handshake, then 0.
- Invalid st_func: accepted, dropped silently, no st_ades.
- Drain:
  - mem_req = !buf_empty.
  - Head outputs stay stable while mem_req=1 and mem_ack=0.
  - mem_ack=1 with mem_req=1 pops the head at the edge; the next entry is presented the following cycle. Back-to-back acks drain one entry per cycle.
  - mem_ack while mem_req=0 is ignored.
- Latency: a store accepted into an empty buffer appears on mem_req in the next cycle.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Pointer wrap: pointers are PTR_W bits and wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- Ordering: strict FIFO; no merging or reordering.

Optional Feature:
- Macro: STORE_BUF_FWD_HIT_EN.
- When defined, two extra ports exist:
  - ld_addr  in  32
  - ld_hit  out  1
- ld_hit is combinational: 1 when any occupied entry, including a head that is being acked this cycle, has a word address equal to ld_addr[31:2].
- The pipeline uses ld_hit to stall a load until the conflicting store drains.
- When not defined, both ports and the compare logic are absent; the pipeline must then drain the buffer before every load.

Test Plan:
- SB, addr 0x1000_0003, data 0x0000_00A5, ack held 1 → next cycle mem_req=1, mem_addr=0x1000_0000, mem_wdata=0xA5A5_A5A5, mem_wstrb=4'b1000; buf_empty=1 one cycle later.
- SH, addr 0x2000_0001 → st_ades=1 for one cycle, mem_req stays 0, buf_count=0. Then SW at 0x2000_0006 → st_ades=1 again.
- Ack held 0, offer 5 SW stores (data 1..5) → first 4 accepted, st_ready=0, buf_count=4. Then ack held 1 → memory sees data 1,2,3,4 in consecutive cycles, and store 5 is accepted once st_ready returns.
- buf_count=2 with st_valid=1 and mem_ack=1 in the same cycle → buf_count stays 2; the new entry drains last.
- rst pulsed while buf_count=3 and mem_req=1 → next cycle mem_req=0, buf_count=0, st_ready=1; later acks have no effect.
- With STORE_BUF_FWD_HIT_EN: SW buffered at 0x3000_0008, ld_addr 0x3000_000A → ld_hit=1; ld_addr 0x3000_000C → ld_hit=0; after the ack → ld_hit=0.
